// File: rtl/canvas_frame_buffer.sv
// Canvas frame store: pixel write port, 2-cycle scan read pipeline and background clear sweep.
// Optional macro CANVAS_BORDER_EN draws a one-pixel white frame around the canvas window.
module canvas_frame_buffer #(
  parameter int X0 = 100,
  parameter int Y0 = 100,
  parameter int W  = 440,
  parameter int H  = 280,
  parameter int CW = 8,
  parameter int AW = $clog2(W*H)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  output logic [CW-1:0] Ro,
  output logic [CW-1:0] Go,
  output logic [CW-1:0] Bo,
  output logic          in_canvas,
  input  logic          wr_en,
  input  logic [9:0]    wr_x,
  input  logic [9:0]    wr_y,
  input  logic [CW-1:0] wr_r,
  input  logic [CW-1:0] wr_g,
  input  logic [CW-1:0] wr_b,
  output logic          wr_dropped,
  input  logic          clear_req,
  input  logic [CW-1:0] bg_r,
  input  logic [CW-1:0] bg_g,
  input  logic [CW-1:0] bg_b,
  output logic          busy
);

  localparam int DEPTH = W*H;
  localparam int PW    = 3*CW;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  if ((X0 + W > 1024) || (Y0 + H > 1024)) begin : g_param_err
    $error("canvas_frame_buffer: canvas window exceeds the 1024x1024 screen space");
  end

  logic [PW-1:0] mem_r [0:DEPTH-1];

  logic [0:0]    state_r;
  logic [AW-1:0] cnt_r;
  logic [PW-1:0] bg_latch_r;

  logic          hit1_r;
  logic          border1_r;
  logic [AW-1:0] addr1_r;
  logic          hit2_r;
  logic [PW-1:0] pix_r;
  logic          dropped_r;

  logic [10:0]   dx_s;
  logic [10:0]   dy_s;
  logic          hit_s;
  logic          border_s;
  logic [AW-1:0] rd_addr_s;
  logic          wr_ok_s;
  logic          we_s;
  logic [AW-1:0] wa_s;
  logic [PW-1:0] wd_s;
  logic          drop_s;

  // Window hit and scan address; 11-bit differences keep DrawX<X0 from wrapping into the window.
  always_comb begin
    dx_s  = {1'b0, DrawX} - 11'(X0);
    dy_s  = {1'b0, DrawY} - 11'(Y0);
    hit_s = (dx_s < 11'(W)) && (dy_s < 11'(H));
    if (hit_s) begin
      rd_addr_s = AW'(dy_s) * AW'(W) + AW'(dx_s);
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
  end

`ifdef CANVAS_BORDER_EN
  // One-pixel ring just outside the window.
  always_comb begin
    border_s = (({1'b0, DrawX} + 11'd1) >= 11'(X0)) && ({1'b0, DrawX} <= 11'(X0 + W)) &&
               (({1'b0, DrawY} + 11'd1) >= 11'(Y0)) && ({1'b0, DrawY} <= 11'(Y0 + H)) &&
               !hit_s;
  end
`else
  assign border_s = 1'b0;
`endif

  // Write port arbitration: the clear sweep owns the memory while it runs.
  always_comb begin
    wr_ok_s = ({1'b0, wr_x} < 11'(W)) && ({1'b0, wr_y} < 11'(H));
    we_s    = 1'b0;
    wa_s    = AW'(wr_y) * AW'(W) + AW'(wr_x);
    wd_s    = {wr_r, wr_g, wr_b};
    case (state_r)
      ST_CLEAR: begin
        we_s = 1'b1;
        wa_s = cnt_r;
        wd_s = bg_latch_r;
      end
      ST_IDLE: begin
        we_s = wr_en && wr_ok_s;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
    drop_s = wr_en && ((state_r != ST_IDLE) || !wr_ok_s);
  end

  // Pixel storage, not reset.
  always_ff @(posedge Clk) begin
    if (we_s) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // Clear sweep FSM.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= ST_CLEAR;
      cnt_r      <= {AW{1'b0}};
      bg_latch_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clear_req) begin
            state_r    <= ST_CLEAR;
            cnt_r      <= {AW{1'b0}};
            bg_latch_r <= {bg_r, bg_g, bg_b};
          end
        end
        ST_CLEAR: begin
          if (cnt_r == AW'(DEPTH - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + AW'(1);
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Read pipeline; the memory read sees the old word when written on the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit1_r    <= 1'b0;
      border1_r <= 1'b0;
      addr1_r   <= {AW{1'b0}};
      hit2_r    <= 1'b0;
      pix_r     <= {PW{1'b0}};
      dropped_r <= 1'b0;
    end else begin
      hit1_r    <= hit_s;
      border1_r <= border_s;
      addr1_r   <= rd_addr_s;
      hit2_r    <= hit1_r;
      dropped_r <= drop_s;
      if (hit1_r) begin
        pix_r <= mem_r[addr1_r];
      end else if (border1_r) begin
        pix_r <= {PW{1'b1}};
      end else begin
        pix_r <= {PW{1'b0}};
      end
    end
  end

  assign Ro         = pix_r[PW-1:2*CW];
  assign Go         = pix_r[2*CW-1:CW];
  assign Bo         = pix_r[CW-1:0];
  assign in_canvas  = hit2_r;
  assign wr_dropped = dropped_r;
  assign busy       = (state_r == ST_CLEAR);

endmodule
